// File: rtl/rv_pkg.sv
// Shared RV front-end types, widths and small PC helpers.
package rv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Next sequential word address; wraps naturally modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

    // Word alignment test for fetch targets.
    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// One-entry {pc, instr} holding buffer absorbing a single word of decode back-pressure.
module ifetch_skid
    import rv_pkg::*;
#(
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_release,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [WIDTH-1:0] i_instr,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_pc,
    output logic [WIDTH-1:0] o_instr
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [WIDTH-1:0] r_instr;

    // Flush beats load beats release; load and release never coincide by construction.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_release) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues word-aligned imem reads, presents {pc, instr} to decode,
// handles redirects and traps misaligned redirect targets into a sticky fault.
module ifetch
    import rv_pkg::*;
#(
    parameter int unsigned     WIDTH    = INSTR_W,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_rd_en,
    output logic [XLEN-1:0]  imem_pc,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [XLEN-1:0]  if_pc,
    output logic             fetch_fault,
    output logic [XLEN-1:0]  fault_pc
);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_pend_valid;
    logic [XLEN-1:0]  r_pend_pc;
    logic [XLEN-1:0]  r_fault_pc;

    logic             w_run;
    logic             w_aligned;
    logic             w_redir;
    logic             w_flush;
    logic             w_issue;
    logic             w_out_valid;
    logic             w_skid_valid;
    logic [XLEN-1:0]  w_skid_pc;
    logic [WIDTH-1:0] w_skid_instr;
    logic             w_skid_load;
    logic             w_skid_release;

    assign w_run     = (r_state == RUN);
    assign w_aligned = pc_aligned(redirect_pc);
    assign w_redir   = redirect_valid && w_run;
    assign w_flush   = rst || w_redir;

    // FSM state register; FAULT is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a misaligned redirect in RUN traps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:   if (redirect_valid && !w_aligned) w_state_nxt = FAULT;
            FAULT: w_state_nxt = FAULT;
            default: w_state_nxt = RUN;
        endcase
    end

    // Issue decision: a redirect forces an issue of an aligned target; otherwise only
    // fetch when the word coming back next cycle is guaranteed a place to land.
    always_comb begin
        w_issue = 1'b0;
        if (!rst && w_run) begin
            if (redirect_valid) begin
                w_issue = w_aligned;
            end else begin
                w_issue = (!w_skid_valid || if_ready) && !(r_pend_valid && !if_ready);
            end
        end
    end

    // Fetch address mux; reset presents the reset vector.
    always_comb begin
        imem_pc = r_fetch_pc;
        if (rst) begin
            imem_pc = RESET_PC;
        end else if (redirect_valid) begin
            imem_pc = redirect_pc;
        end
    end

    assign imem_rd_en = w_issue;

    // Sequential PC, pending request and fault capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_fault_pc   <= '0;
        end else begin
            r_pend_valid <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= pc_next(imem_pc);
                r_pend_pc  <= imem_pc;
            end
            if (w_redir && !w_aligned) begin
                r_fault_pc <= redirect_pc;
            end
        end
    end

    // Park the returning word when decode stalls and the buffer is free.
    assign w_skid_load    = !w_flush && r_pend_valid && !w_skid_valid && !if_ready;
    assign w_skid_release = w_skid_valid && if_ready;

    ifetch_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_load    (w_skid_load),
        .i_release (w_skid_release),
        .i_pc      (r_pend_pc),
        .i_instr   (imem_instr),
        .o_valid   (w_skid_valid),
        .o_pc      (w_skid_pc),
        .o_instr   (w_skid_instr)
    );

    // Output select: skid has priority (older word), then the word returning from imem.
    assign w_out_valid = !rst && w_run && !redirect_valid && (w_skid_valid || r_pend_valid);

    always_comb begin
        if_valid = w_out_valid;
        if_pc    = '0;
        if_instr = '0;
        if (w_out_valid) begin
            if (w_skid_valid) begin
                if_pc    = w_skid_pc;
                if_instr = w_skid_instr;
            end else begin
                if_pc    = r_pend_pc;
                if_instr = imem_instr;
            end
        end
    end

    assign fetch_fault = !rst && (r_state == FAULT);
    assign fault_pc    = rst ? '0 : r_fault_pc;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed stimulus with a scoreboard of expected deliveries.
module tb_ifetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_rd_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic        b_imem_rd_en;
    logic [31:0] b_imem_pc;
    logic [31:0] b_imem_instr;
    logic        b_if_valid;
    logic [31:0] b_if_instr;
    logic [31:0] b_if_pc;
    logic        b_fetch_fault;
    logic [31:0] b_fault_pc;

    ifetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en     (imem_rd_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    ifetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en     (b_imem_rd_en),
        .imem_pc        (b_imem_pc),
        .imem_instr     (b_imem_instr),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (b_if_valid),
        .if_ready       (1'b1),
        .if_instr       (b_if_instr),
        .if_pc          (b_if_pc),
        .fetch_fault    (b_fetch_fault),
        .fault_pc       (b_fault_pc)
    );

    // Behavioural imem: one-cycle latency, word = A000_0000 | addr.
    always @(posedge clk) begin
        imem_instr   <= imem_rd_en   ? (32'hA000_0000 | imem_pc)   : 32'hDEAD_BEEF;
        b_imem_instr <= b_imem_rd_en ? (32'hA000_0000 | b_imem_pc) : 32'hDEAD_BEEF;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_rd_en"}, imem_rd_en, 1'b0);
        chk({tag, "_imem_pc"}, imem_pc, 32'h0);
        chk1({tag, "_if_valid"}, if_valid, 1'b0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        fork
            // Monitor: every accepted word must match the next expected pc.
            begin
                logic [31:0] e;
                while (!done) begin
                    mid();
                    if (if_valid && if_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_unexpected actual=%h required=none", if_pc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_if_pc", if_pc, e);
                            chk("sb_if_instr", if_instr, 32'hA000_0000 | e);
                        end
                    end
                end
            end
            // Stimulus
            begin
                tick(); tick(); tick();
                mid();
                chk_reset_outputs("rst");
                chk1("wrap_rst_rd_en", b_imem_rd_en, 1'b0);
                chk("wrap_rst_imem_pc", b_imem_pc, 32'hFFFF_FFF8);

                // C0: first fetch
                tick(); rst = 1'b0;
                exp_q.push_back(32'h0); exp_q.push_back(32'h4);
                exp_q.push_back(32'h8); exp_q.push_back(32'hC);
                mid();
                chk1("c0_rd_en", imem_rd_en, 1'b1);
                chk("c0_imem_pc", imem_pc, 32'h0);
                chk1("c0_if_valid", if_valid, 1'b0);
                chk("wrap_c0_pc", b_imem_pc, 32'hFFFF_FFF8);
                // C1
                tick(); mid();
                chk("c1_imem_pc", imem_pc, 32'h4);
                chk("wrap_c1_pc", b_imem_pc, 32'hFFFF_FFFC);
                chk1("wrap_c1_if_valid", b_if_valid, 1'b1);
                chk("wrap_c1_if_pc", b_if_pc, 32'hFFFF_FFF8);
                chk("wrap_c1_if_instr", b_if_instr, 32'hFFFF_FFF8);
                chk1("wrap_c1_fault", b_fetch_fault, 1'b0);
                chk("wrap_c1_fault_pc", b_fault_pc, 32'h0);
                // C2: wrap to 0
                tick(); mid();
                chk1("wrap_c2_rd_en", b_imem_rd_en, 1'b1);
                chk("wrap_c2_pc", b_imem_pc, 32'h0);
                // C3, C4
                tick(); mid();
                chk("wrap_c3_if_pc", b_if_pc, 32'h0);
                tick(); mid();
                // C5..C7: stall with 0x10 presented
                tick(); if_ready = 1'b0; mid();
                chk("c5_if_pc", if_pc, 32'h10);
                chk1("c5_rd_en", imem_rd_en, 1'b0);
                for (int i = 0; i < 2; i++) begin
                    tick(); mid();
                    chk1("stall_if_valid", if_valid, 1'b1);
                    chk("stall_if_pc", if_pc, 32'h10);
                    chk1("stall_rd_en", imem_rd_en, 1'b0);
                end
                // C8: release, skid word delivered and next fetch issued together
                tick(); if_ready = 1'b1;
                exp_q.push_back(32'h10); exp_q.push_back(32'h14);
                mid();
                chk("c8_if_pc", if_pc, 32'h10);
                chk1("c8_rd_en", imem_rd_en, 1'b1);
                chk("c8_imem_pc", imem_pc, 32'h14);
                // C9
                tick(); mid();
                // C10: stall with 0x18 presented
                tick(); if_ready = 1'b0; mid();
                chk1("c10_rd_en", imem_rd_en, 1'b0);
                // C11: redirect with 0x18 in skid
                tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; mid();
                chk1("redir_if_valid", if_valid, 1'b0);
                chk1("redir_rd_en", imem_rd_en, 1'b1);
                chk("redir_imem_pc", imem_pc, 32'h40);
                // C12
                tick(); redirect_valid = 1'b0; if_ready = 1'b1;
                exp_q.push_back(32'h40); exp_q.push_back(32'h44);
                mid();
                chk1("c12_if_valid", if_valid, 1'b1);
                chk("c12_if_pc", if_pc, 32'h40);
                chk("c12_imem_pc", imem_pc, 32'h44);
                // C13
                tick(); mid();
                // C14: misaligned redirect
                tick(); redirect_valid = 1'b1; redirect_pc = 32'h42; mid();
                chk1("mis_if_valid", if_valid, 1'b0);
                chk1("mis_rd_en", imem_rd_en, 1'b0);
                // C15
                tick(); redirect_valid = 1'b0; mid();
                chk1("c15_fault", fetch_fault, 1'b1);
                chk("c15_fault_pc", fault_pc, 32'h42);
                chk1("c15_rd_en", imem_rd_en, 1'b0);
                chk1("c15_if_valid", if_valid, 1'b0);
                // C16: aligned redirect ignored in FAULT
                tick(); redirect_valid = 1'b1; redirect_pc = 32'h80; mid();
                chk1("c16_rd_en", imem_rd_en, 1'b0);
                chk1("c16_if_valid", if_valid, 1'b0);
                // C17
                tick(); redirect_valid = 1'b0; mid();
                chk1("c17_fault", fetch_fault, 1'b1);
                chk("c17_fault_pc", fault_pc, 32'h42);
                chk1("c17_if_valid", if_valid, 1'b0);
                // C18: reset clears the fault
                tick(); rst = 1'b1; mid();
                chk_reset_outputs("c18");
                // C19
                tick(); rst = 1'b0; exp_q.push_back(32'h0); mid();
                chk1("c19_rd_en", imem_rd_en, 1'b1);
                chk("c19_imem_pc", imem_pc, 32'h0);
                chk1("c19_fault", fetch_fault, 1'b0);
                // C20: 0x4 goes in flight
                tick(); mid();
                chk("c20_imem_pc", imem_pc, 32'h4);
                // C21: reset mid-stream
                tick(); rst = 1'b1; mid();
                chk_reset_outputs("c21");
                // C22
                tick(); rst = 1'b0;
                exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
                mid();
                chk1("c22_if_valid", if_valid, 1'b0);
                chk1("c22_rd_en", imem_rd_en, 1'b1);
                chk("c22_imem_pc", imem_pc, 32'h0);
                // C23..C25 deliver 0,4,8
                tick(); tick(); tick();
                // C26: stop consuming
                tick(); if_ready = 1'b0;
                tick(); tick();
                done = 1'b1;
            end
        join

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
